bcd_subtractor_serial: RTL and testbench

Digit-serial multi-digit BCD subtractor: computes |a − b| and its sign for two packed-BCD operands, one decimal digit per clock, with a start/busy/done handshake. It complements the combinational single-digit BCD adder in the arithmetic library: it handles the subtract direction and arbitrary operand width at low area, for the decimal display and counter datapaths.

---
 rtl/bcd_subtractor_serial.sv | 178 +++++++++++++++++
 tb/tb_bcd_subtractor_serial.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_subtractor_serial.sv
// ---------------------------------------------------------------------------
// bcd_subtractor_serial
//
// Digit-serial packed-BCD subtractor. Computes |a - b| and its sign, one
// decimal digit per clock, least significant digit first. When a < b the
// first pass leaves the ten's complement of the magnitude, so a second pass
// (FIX) complements it back to the magnitude.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    operation request, sampled only while idle
//   a, b     minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy     high in every state except IDLE
//   done     one-cycle pulse; diff/neg/invalid are valid from this cycle on
//   diff     |a - b|, packed BCD
//   neg      1 when a < b
//   invalid  1 when any digit of a or b was above 9
// ---------------------------------------------------------------------------
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

  state_t        state, state_next;

  // Working registers; a_work/b_work/r_work shift right one digit per cycle
  // so the active digit is always in bits [3:0].
  logic [W-1:0]  a_work, b_work, r_work;
  logic          borrow;
  logic [CW-1:0] cnt;

  logic          in_bad;
  logic          last;
  logic [3:0]    x, y, dig;
  logic [4:0]    t;
  logic          bout;
  logic [W+3:0]  a_cat, b_cat, r_cat;
  logic [W-1:0]  a_shift, b_shift, r_next;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    in_bad = has_bad_digit(a) | has_bad_digit(b);
    last   = (cnt == LAST);

    // SUB computes a_i - b_i - borrow; FIX computes 0 - r_i - borrow.
    x = (state == FIX) ? 4'd0 : a_work[3:0];
    y = (state == FIX) ? r_work[3:0] : b_work[3:0];

    // Biased by +10 so the intermediate never goes negative (range 0..19).
    t = 5'd10 + {1'b0, x} - {1'b0, y} - {4'd0, borrow};
    if (t >= 5'd10) begin
      dig  = 4'(t - 5'd10);
      bout = 1'b0;
    end else begin
      dig  = t[3:0];
      bout = 1'b1;
    end

    // New digit enters at the top; after DIGITS cycles r_work is aligned.
    a_cat   = {4'd0, a_work};
    b_cat   = {4'd0, b_work};
    r_cat   = {dig, r_work};
    a_shift = a_cat[W+3:4];
    b_shift = b_cat[W+3:4];
    r_next  = r_cat[W+3:4];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = in_bad ? DONE : SUB;
      SUB:  if (last)  state_next = bout ? FIX : DONE;
      FIX:  if (last)  state_next = DONE;
      DONE:            state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: working registers are reset along with the outputs so an aborted
  // operation leaves no stale operand or borrow behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_work  <= '0;
      b_work  <= '0;
      r_work  <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      neg     <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_work <= a;
            b_work <= b;
            r_work <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            if (in_bad) begin
              diff    <= '0;
              neg     <= 1'b0;
              invalid <= 1'b1;
            end
          end
        end
        SUB: begin
          a_work <= a_shift;
          b_work <= b_shift;
          r_work <= r_next;
          if (last) begin
            cnt    <= '0;
            borrow <= 1'b0;
            if (!bout) begin
              diff    <= r_next;
              neg     <= 1'b0;
              invalid <= 1'b0;
            end
          end else begin
            cnt    <= cnt + CW'(1);
            borrow <= bout;
          end
        end
        FIX: begin
          r_work <= r_next;
          if (last) begin
            cnt     <= '0;
            borrow  <= 1'b0;
            diff    <= r_next;
            neg     <= 1'b1;
            invalid <= 1'b0;
          end else begin
            cnt    <= cnt + CW'(1);
            borrow <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_subtractor_serial
//
// Self-checking bench for bcd_subtractor_serial with DIGITS=4. Expected
// results come from an integer reference: operands are converted to decimal
// values, subtracted, and the magnitude converted back to BCD. Inputs are
// driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_subtractor_serial;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] diff;
  logic        neg, invalid;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] prev_diff = '0;
  logic        prev_neg  = 1'b0;
  logic        prev_inv  = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        neg;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  bcd_subtractor_serial #(.DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .neg     (neg),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---- reference model -----------------------------------------------------
  function automatic bit bcd_bad(input logic [15:0] v);
    bit bad;
    bad = 0;
    for (int i = 0; i < D; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  function automatic int bcd_val(input logic [15:0] v);
    int s;
    s = 0;
    for (int i = D - 1; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int m;
    r = '0;
    m = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < D; i++)
      if ($urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---- one operation: start, watch every busy cycle, check result ----------
  // With noise set, start is held high and operands scrambled during every
  // busy cycle, including DONE; all of that must be ignored.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic [15:0] ed, input logic en, input logic ei,
                        input int el, input bit noise, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(posedge clk);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 4 * D + 8) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1;
        check({tag, " latency"}, lat, el);
        check({tag, " busy@done"}, busy, 1'b1);
        check({tag, " diff"}, diff, ed);
        check({tag, " neg"}, neg, en);
        check({tag, " invalid"}, invalid, ei);
      end else begin
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " hold"}, {diff, neg, invalid}, {prev_diff, prev_neg, prev_inv});
      end
      if (noise) begin
        start = 1'b1;
        a     = 16'($urandom);
        b     = 16'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) check({tag, " timeout"}, lat, el);
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle after done"}, {busy, done}, 2'b00);
    check({tag, " result kept"}, {diff, neg, invalid}, {ed, en, ei});
    prev_diff = ed;
    prev_neg  = en;
    prev_inv  = ei;
  endtask

  initial begin
    vecs[0] = '{16'h5321, 16'h1234, 16'h4087, 1'b0, 1'b0, D + 1};
    vecs[1] = '{16'h1234, 16'h5321, 16'h4087, 1'b1, 1'b0, 2 * D + 1};
    vecs[2] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 2 * D + 1};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, D + 1};
    vecs[4] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, D + 1};
    vecs[5] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vecs[6] = '{16'h0050, 16'h0049, 16'h0001, 1'b0, 1'b0, D + 1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset outputs", {busy, done, diff, neg, invalid}, 20'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle", {busy, done, diff, neg, invalid}, 20'h0);

    // Directed table.
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].neg, vecs[i].inv,
             vecs[i].lat, 1'b0, $sformatf("vec%0d", i));

    // start held high through the whole run and during DONE: ignored.
    run_op(16'h1234, 16'h5321, 16'h4087, 1'b1, 1'b0, 2 * D + 1, 1'b1, "hs_neg");
    run_op(16'h5321, 16'h1234, 16'h4087, 1'b0, 1'b0, D + 1, 1'b1, "hs_pos");

    // Randomized operands against the integer model.
    for (int n = 0; n < 30; n++) begin
      logic [15:0] ra, rb, ed;
      logic en, ei;
      int el, va, vb;
      ra = rand_bcd();
      rb = rand_bcd();
      if (bcd_bad(ra) || bcd_bad(rb)) begin
        ed = '0; en = 1'b0; ei = 1'b1; el = 1;
      end else begin
        va = bcd_val(ra);
        vb = bcd_val(rb);
        en = (va < vb);
        ed = to_bcd(en ? vb - va : va - vb);
        ei = 1'b0;
        el = en ? 2 * D + 1 : D + 1;
      end
      run_op(ra, rb, ed, en, ei, el, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // Reset mid-operation: leave a non-zero result first, then abort at k+3.
    run_op(16'h5321, 16'h1234, 16'h4087, 1'b0, 1'b0, D + 1, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h5321;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort busy before rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort outputs cleared", {busy, done, diff, neg, invalid}, 20'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no done in reset", {busy, done}, 2'b00);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * D + 2; i++) begin
      @(negedge clk);
      check("no done after abort", {busy, done}, 2'b00);
    end
    prev_diff = '0;
    prev_neg  = 1'b0;
    prev_inv  = 1'b0;
    run_op(16'h0050, 16'h0049, 16'h0001, 1'b0, 1'b0, D + 1, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
